// File: rtl/router_output_arbiter_pkg.sv
// Shared types for the mesh router output arbiters: AXI-Stream flit and
// backpressure structs, the routing-header TID marker and the arbiter states.
package router_output_arbiter_pkg;

  localparam int AXIS_TDATA_W = 32;
  localparam int AXIS_TID_W   = 4;

  // A flit whose TID carries this value opens a packet and may request a channel.
  localparam logic [AXIS_TID_W-1:0] ROUTING_HEADER = 4'hA;

  typedef struct packed {
    logic [AXIS_TID_W-1:0]   TID;
    logic [AXIS_TDATA_W-1:0] TDATA;
  } axis_data_t;

  typedef struct packed {
    logic       TVALID;
    logic       TLAST;
    axis_data_t data;
  } axis_mosi_t;

  typedef struct packed {
    logic TREADY;
  } axis_miso_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

endpackage

// File: rtl/router_output_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: the search starts just after the
// last-served index and wraps, the first requester found wins.
module rr_priority_picker #(
  parameter int N = 5,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_winner,
  output logic         o_any
);

  // Scan from the farthest offset down to the nearest one so the nearest requester overwrites the rest.
  always_comb begin
    int idx;
    o_winner = '0;
    o_any    = 1'b0;
    for (int off = N; off >= 1; off--) begin
      idx = int'(i_ptr) + off;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (i_req[idx]) begin
        o_winner = W'(idx);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_output_arbiter.sv
// Per-output-channel packet arbiter. Locks the channel to one input from the
// routing-header flit through the TLAST handshake, with round-robin fairness.
// Optional performance counters are built when ARB_PMU_EN is defined.
module router_output_arbiter
  import router_output_arbiter_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH    = 32,
  parameter int INPUT_NUMBER       = 5,
  parameter int INPUT_NUMBER_WIDTH = $clog2(INPUT_NUMBER)
`ifdef ARB_PMU_EN
  ,
  parameter int PMU_COUNTER_WIDTH  = 32
`endif
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  axis_mosi_t                    in_mosi_i [INPUT_NUMBER],
  output axis_miso_t                    in_miso_o [INPUT_NUMBER],
  output axis_mosi_t                    out_mosi_o,
  input  axis_miso_t                    out_miso_i,
  output logic [INPUT_NUMBER_WIDTH-1:0] grant_o,
  output logic                          locked_o,
  output logic                          err_o
`ifdef ARB_PMU_EN
  ,
  output logic [PMU_COUNTER_WIDTH-1:0]  pmu_packets_o,
  output logic [PMU_COUNTER_WIDTH-1:0]  pmu_stall_o
`endif
);

  // The flit struct has a fixed TDATA width, so a mismatching override is a build error.
  if (AXIS_DATA_WIDTH != AXIS_TDATA_W) begin : g_width_check
    $error("router_output_arbiter: AXIS_DATA_WIDTH must match the package TDATA width");
  end

  arb_state_t                    r_state;
  arb_state_t                    w_next_state;
  logic [INPUT_NUMBER_WIDTH-1:0] r_grant;
  logic [INPUT_NUMBER_WIDTH-1:0] r_ptr;
  logic                          r_err;
  logic [INPUT_NUMBER-1:0]       w_req;
  logic [INPUT_NUMBER-1:0]       w_bad;
  logic [INPUT_NUMBER_WIDTH-1:0] w_winner;
  logic                          w_any;
  axis_mosi_t                    w_sel;
  logic                          w_release;

  // Classify each input: a valid header is a request, any other valid flit while idle is a violation.
  always_comb begin
    w_req = '0;
    w_bad = '0;
    for (int i = 0; i < INPUT_NUMBER; i++) begin
      w_req[i] = in_mosi_i[i].TVALID && (in_mosi_i[i].data.TID == ROUTING_HEADER);
      w_bad[i] = in_mosi_i[i].TVALID && (in_mosi_i[i].data.TID != ROUTING_HEADER);
    end
  end

  rr_priority_picker #(
    .N (INPUT_NUMBER),
    .W (INPUT_NUMBER_WIDTH)
  ) u_picker (
    .i_req    (w_req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_sel     = in_mosi_i[r_grant];
  assign w_release = (r_state == ARB_LOCKED) && w_sel.TVALID && w_sel.TLAST && out_miso_i.TREADY;

  // Next-state and pass-through muxing; the channel is silent while idle.
  always_comb begin
    w_next_state = r_state;
    out_mosi_o   = '0;
    for (int i = 0; i < INPUT_NUMBER; i++) begin
      in_miso_o[i] = '0;
    end
    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_next_state = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        out_mosi_o         = w_sel;
        in_miso_o[r_grant] = out_miso_i;
        if (w_release) begin
          w_next_state = ARB_IDLE;
        end
      end
      default: begin
        w_next_state = ARB_IDLE;
      end
    endcase
  end

  // State, grant, fairness pointer and sticky error; the pointer starts at the last index so input 0 leads.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_ptr   <= INPUT_NUMBER_WIDTH'(INPUT_NUMBER - 1);
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == ARB_IDLE) && w_any) begin
        r_grant <= w_winner;
      end
      if (w_release) begin
        r_ptr <= r_grant;
      end
      if ((r_state == ARB_IDLE) && (|w_bad)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign grant_o  = r_grant;
  assign locked_o = (r_state == ARB_LOCKED);
  assign err_o    = r_err;

`ifdef ARB_PMU_EN
  logic [PMU_COUNTER_WIDTH-1:0] r_pmu_packets;
  logic [PMU_COUNTER_WIDTH-1:0] r_pmu_stall;
  logic                         w_stall;

  assign w_stall = (r_state == ARB_LOCKED) && w_sel.TVALID && !out_miso_i.TREADY;

  // Saturating counters of completed packets and backpressured locked cycles.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pmu_packets <= '0;
      r_pmu_stall   <= '0;
    end else begin
      if (w_release && (r_pmu_packets != '1)) begin
        r_pmu_packets <= r_pmu_packets + 1'b1;
      end
      if (w_stall && (r_pmu_stall != '1)) begin
        r_pmu_stall <= r_pmu_stall + 1'b1;
      end
    end
  end

  assign pmu_packets_o = r_pmu_packets;
  assign pmu_stall_o   = r_pmu_stall;
`endif

endmodule

// File: tb/tb_router_output_arbiter.sv
// Testbench for router_output_arbiter: directed scenarios plus randomized
// traffic, checked every cycle against a packet-level reference model.
// Counter checks are included when ARB_PMU_EN is defined.
module tb_router_output_arbiter;
  import router_output_arbiter_pkg::*;

  localparam int N = 5;
  localparam int W = $clog2(N);

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  axis_mosi_t inMosi [N];
  axis_miso_t inMiso [N];
  axis_mosi_t outMosi;
  axis_miso_t outMiso;
  logic [W-1:0] grant;
  logic       locked;
  logic       err;
`ifdef ARB_PMU_EN
  logic [31:0] pmuPackets;
  logic [31:0] pmuStall;
`endif

  int checks = 0;
  int errors = 0;

  int owner;
  int ptr;
  int grantExp;
  int pktsExp;
  int stallExp;
  bit errExp;
  bit expReady [N];

  int remFlits [N];
  int flitIdx  [N];
  int pktsLeft [N];
  int fixedLen [N];
  int pktNo    [N];
  bit forceBad [N];
  int validPct;
  int readyPct;
  int maxLen;

  int grantLog [$];
  bit prevLocked;

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  router_output_arbiter dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .in_mosi_i     (inMosi),
    .in_miso_o     (inMiso),
    .out_mosi_o    (outMosi),
    .out_miso_i    (outMiso),
    .grant_o       (grant),
    .locked_o      (locked),
    .err_o         (err)
`ifdef ARB_PMU_EN
    ,
    .pmu_packets_o (pmuPackets),
    .pmu_stall_o   (pmuStall)
`endif
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void nextPacket(int i);
    if (pktsLeft[i] > 0) begin
      remFlits[i] = (fixedLen[i] > 0) ? fixedLen[i] : int'($urandom_range(maxLen, 1));
      flitIdx[i]  = 0;
      pktNo[i]    = pktNo[i] + 1;
    end else begin
      remFlits[i] = 0;
    end
  endfunction

  function automatic void queuePackets(int i, int n, int len);
    pktsLeft[i] = n;
    fixedLen[i] = len;
    nextPacket(i);
  endfunction

  function automatic void modelReset();
    owner    = -1;
    ptr      = N - 1;
    grantExp = 0;
    errExp   = 1'b0;
    pktsExp  = 0;
    stallExp = 0;
    for (int i = 0; i < N; i++) begin
      remFlits[i] = 0;
      pktsLeft[i] = 0;
      fixedLen[i] = 0;
      flitIdx[i]  = 0;
      forceBad[i] = 1'b0;
      expReady[i] = 1'b0;
    end
    grantLog.delete();
    prevLocked = 1'b0;
  endfunction

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      inMosi[i] = '0;
      if (forceBad[i]) begin
        inMosi[i].TVALID     = 1'b1;
        inMosi[i].data.TID   = 4'h3;
        inMosi[i].data.TDATA = 32'hBAD0_0000 | 32'(i);
      end else if (remFlits[i] > 0) begin
        inMosi[i].TVALID     = ($urandom_range(99, 0) < validPct);
        inMosi[i].TLAST      = (remFlits[i] == 1);
        inMosi[i].data.TID   = (flitIdx[i] == 0) ? ROUTING_HEADER : 4'h3;
        inMosi[i].data.TDATA = {8'(i), 8'(pktNo[i]), 16'(flitIdx[i])};
      end
    end
    outMiso.TREADY = ($urandom_range(99, 0) < readyPct);
  endtask

  task automatic checkOutput();
    axis_mosi_t   expOut;
    logic [N-1:0] expVec;
    logic [N-1:0] obsVec;
    expOut = '0;
    for (int i = 0; i < N; i++) begin
      expReady[i] = 1'b0;
    end
    if (owner >= 0) begin
      expOut          = inMosi[owner];
      expReady[owner] = outMiso.TREADY;
    end
    for (int i = 0; i < N; i++) begin
      expVec[i] = expReady[i];
      obsVec[i] = inMiso[i].TREADY;
    end
    checkVal("out_mosi", 64'(outMosi), 64'(expOut));
    checkVal("in_tready", 64'(obsVec), 64'(expVec));
    checkVal("grant_o", 64'(grant), 64'(grantExp));
    checkVal("locked_o", 64'(locked), 64'(owner >= 0));
    checkVal("err_o", 64'(err), 64'(errExp));
`ifdef ARB_PMU_EN
    checkVal("pmu_packets", 64'(pmuPackets), 64'(pktsExp));
    checkVal("pmu_stall", 64'(pmuStall), 64'(stallExp));
`endif
    if (locked === 1'b1 && !prevLocked) begin
      grantLog.push_back(int'(grant));
    end
    prevLocked = (locked === 1'b1);
  endtask

  // Packet-level model: who owns the channel, who is next by fairness, and how flits advance.
  task automatic modelUpdate();
    bit found;
    int c;
    if (owner < 0) begin
      for (int i = 0; i < N; i++) begin
        if (inMosi[i].TVALID && inMosi[i].data.TID != ROUTING_HEADER) begin
          errExp = 1'b1;
        end
      end
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (ptr + k) % N;
        if (!found && inMosi[c].TVALID && inMosi[c].data.TID == ROUTING_HEADER) begin
          found    = 1'b1;
          owner    = c;
          grantExp = c;
        end
      end
    end else if (inMosi[owner].TVALID) begin
      if (!outMiso.TREADY) begin
        stallExp++;
      end else if (inMosi[owner].TLAST) begin
        ptr   = owner;
        owner = -1;
        pktsExp++;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!forceBad[i] && inMosi[i].TVALID && expReady[i]) begin
        flitIdx[i]++;
        remFlits[i]--;
        if (remFlits[i] == 0) begin
          pktsLeft[i]--;
          nextPacket(i);
        end
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      applyStimulus();
      @(negedge clk_i);
      checkOutput();
      @(posedge clk_i);
      modelUpdate();
      #1;
    end
  endtask

  task automatic doReset();
    rst_n_i = 1'b0;
    modelReset();
    applyStimulus();
    #1;
    checkOutput();
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    int order [6];
    order    = '{0, 1, 2, 3, 4, 0};
    validPct = 100;
    readyPct = 100;
    maxLen   = 4;
    for (int i = 0; i < N; i++) begin
      pktNo[i] = 0;
    end
    rst_n_i = 1'b0;
    modelReset();
    applyStimulus();
    #1;
    checkOutput();
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;

    $display("[TB] single input packet");
    queuePackets(2, 1, 5);
    step(9);
    checkVal("single_lock_count", 64'(grantLog.size()), 64'(1));
    if (grantLog.size() >= 1) checkVal("single_grant", 64'(grantLog[0]), 64'(2));

    $display("[TB] simultaneous requests");
    doReset();
    for (int i = 0; i < N; i++) begin
      queuePackets(i, (i == 0) ? 2 : 1, 3);
    end
    step(40);
    checkVal("rr_lock_count", 64'(grantLog.size()), 64'(6));
    for (int k = 0; k < 6; k++) begin
      if (k < grantLog.size()) checkVal("rr_order", 64'(grantLog[k]), 64'(order[k]));
    end

    $display("[TB] backpressure");
    doReset();
    queuePackets(1, 1, 6);
    step(3);
    readyPct = 0;
    step(4);
    readyPct = 100;
    step(6);
`ifdef ARB_PMU_EN
    checkVal("bp_stall_total", 64'(pmuStall), 64'(4));
    checkVal("bp_packets_total", 64'(pmuPackets), 64'(1));
`endif

    $display("[TB] single-flit packet");
    doReset();
    queuePackets(3, 1, 1);
    step(4);
    checkVal("sflit_lock_count", 64'(grantLog.size()), 64'(1));
    checkVal("sflit_locked_after", 64'(locked), 64'(0));
`ifdef ARB_PMU_EN
    checkVal("sflit_packets", 64'(pmuPackets), 64'(1));
`endif

    $display("[TB] protocol violation");
    doReset();
    forceBad[1] = 1'b1;
    queuePackets(3, 1, 2);
    step(8);
    checkVal("viol_err", 64'(err), 64'(1));
    checkVal("viol_lock_count", 64'(grantLog.size()), 64'(1));
    if (grantLog.size() >= 1) checkVal("viol_served", 64'(grantLog[0]), 64'(3));
    forceBad[1] = 1'b0;
    step(2);
    checkVal("viol_sticky", 64'(err), 64'(1));

    $display("[TB] reset mid-packet");
    doReset();
    queuePackets(2, 1, 4);
    step(3);
    checkVal("midrst_locked_before", 64'(locked), 64'(1));
    doReset();
    queuePackets(4, 1, 2);
    queuePackets(0, 1, 2);
    step(12);
    checkVal("midrst_lock_count", 64'(grantLog.size()), 64'(2));
    if (grantLog.size() >= 2) begin
      checkVal("midrst_first", 64'(grantLog[0]), 64'(0));
      checkVal("midrst_second", 64'(grantLog[1]), 64'(4));
    end

    $display("[TB] randomized traffic");
    doReset();
    validPct = 75;
    readyPct = 65;
    maxLen   = 5;
    for (int i = 0; i < N; i++) begin
      queuePackets(i, int'($urandom_range(3, 1)), 0);
    end
    step(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_output_arbiter.md
# router_output_arbiter

Per-output-channel packet arbiter of the mesh router. It sits directly downstream of the per-input routing stages. Each routing stage drives one AXI-Stream request toward every output channel. This block selects one requesting input with round-robin fairness and locks the channel to that input from the routing-header flit to the TLAST flit. It then forwards flits and backpressure between the granted input and the output link, and reports the current grant index back to the routing stages.

## Interface
Parameters:
- AXIS_DATA_WIDTH, 32, TDATA width; carried inside axis_mosi_t.
- INPUT_NUMBER, 5, number of competing inputs (one per router input port).
- INPUT_NUMBER_WIDTH, $clog2(INPUT_NUMBER), grant index width.
- PMU_COUNTER_WIDTH, 32, width of each performance counter (used only with ARB_PMU_EN).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- in_mosi_i  in  axis_mosi_t[INPUT_NUMBER]  flits from each input's routing stage.
- in_miso_o  out  axis_miso_t[INPUT_NUMBER]  TREADY back to each input.
- out_mosi_o  out  axis_mosi_t  flit to the output link.
- out_miso_i  in  axis_miso_t  TREADY from the output link.
- grant_o  out  INPUT_NUMBER_WIDTH  index of the locked or last-granted input.
- locked_o  out  1  channel is owned by a packet.
- err_o  out  1  sticky protocol-violation flag.
- pmu_packets_o  out  PMU_COUNTER_WIDTH  completed packets (ARB_PMU_EN only).
- pmu_stall_o  out  PMU_COUNTER_WIDTH  backpressure cycles (ARB_PMU_EN only).

## Operation
- The FSM has two states, IDLE and LOCKED. It resets to IDLE.
- **Request definition:** input i requests when `in_mosi_i[i].TVALID && in_mosi_i[i].data.TID == ROUTING_HEADER`.
- **Round-robin selection:** the pointer ptr_q holds the last-served index. The search starts at ptr_q+1 and wraps from INPUT_NUMBER-1 to 0. The first requester found wins.
- **IDLE:**
  - All in_miso_o.TREADY are 0 and out_mosi_o is '0.
  - If any input requests, grant_q <= winner and the FSM moves to LOCKED.
  - If no input requests, the FSM stays in IDLE.
- **LOCKED:**
  - out_mosi_o = in_mosi_i[grant_q].
  - in_miso_o[grant_q] = out_miso_i.
  - All other in_miso_o are 0, and all other inputs are stalled.
- **Release:** on a handshake (TVALID && TREADY) with TLAST=1, the FSM returns to IDLE and ptr_q <= grant_q.
- **Single-flit packets:** a header flit carrying TLAST=1 releases on its own handshake.
- **Protocol violation:** in IDLE, any input presenting TVALID with TID != ROUTING_HEADER sets err_o. That input is never granted. err_o clears only on reset.
- **Output assignments:** grant_o = grant_q and locked_o = (state == LOCKED).

## Timing
- Arbitration latency: the header is first presented on out_mosi_o one cycle after the request is seen in IDLE.
- After lock, forwarding is combinational in both directions: zero-latency pass-through, with no buffering.
- Sustained throughput while LOCKED: 1 flit/cycle.
- Minimum packet overhead: 1 idle cycle between packets on the same channel (the release cycle followed by the IDLE cycle).
- **Simultaneous requests:** exactly one wins per IDLE cycle, according to ptr_q.
- **TVALID dropped mid-packet:** the channel stays LOCKED. Lock is released only by the TLAST handshake.
- **Reset values (also apply on reset mid-packet):**
  - state IDLE
  - ptr_q = INPUT_NUMBER-1, so input 0 has first priority
  - grant_q = 0
  - err_o = 0
  - counters = 0
  - all TREADY/TVALID outputs = 0
- On reset mid-packet, the partial packet is abandoned. No recovery is attempted.

## Configuration
- Macro: **ARB_PMU_EN**.
- **Defined:**
  - pmu_packets_o increments on every releasing TLAST handshake.
  - pmu_stall_o increments on every LOCKED cycle with out_mosi_o.TVALID=1 and out_miso_i.TREADY=0.
  - Both counters saturate at all-ones; they do not wrap.
- **Undefined:** the pmu_* ports and PMU_COUNTER_WIDTH are absent, and no counter logic is generated.

## Structure
- A shared package holds:
  - axis_mosi_t and axis_miso_t
  - the ROUTING_HEADER TID constant
  - the arbiter state enum arb_state_t {ARB_IDLE, ARB_LOCKED}
- One natural sub-module is **rr_priority_picker**. It is purely combinational: it takes a request vector and ptr_q, and returns the winner index and an any-request flag. It is reused by the router's other arbiters.
- Counters are instantiated inline.

## Test plan
- **Single input:** input 2 sends header + 3 data + TLAST with TREADY=1 -> grant_o=2 and locked_o=1 one cycle after the request; 5 flits appear in order on out_mosi_o; locked_o=0 after the TLAST handshake.
- **Simultaneous requests:** all 5 inputs request from reset -> grant order is 0,1,2,3,4,0; no packet interleaves with another.
- **Backpressure:** out TREADY=0 for 4 cycles mid-packet -> the granted input's TREADY=0 and data is held stable; with ARB_PMU_EN, pmu_stall_o=4.
- **Single-flit packet:** header with TLAST=1 -> released after one handshake; pmu_packets_o=1.
- **Protocol violation:** input 1 drives a non-header flit in IDLE -> err_o=1 (sticky) and input 1 is never granted; a header on input 3 is still served.
- **Reset mid-packet:** assert rst_n_i during a LOCKED transfer -> all outputs return to their reset values immediately; after release, input 0 wins first.
